// File: rtl/muldiv_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : muldiv_seq_pkg                                               |
// | Description : Shared constants for the sequential RV32M multiply/divide    |
// |               unit: register width, shared-ALU op codes, MD funct3 codes,  |
// |               FSM state encoding and operand-signedness helpers.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package muldiv_seq_pkg;

   localparam int REG_WIDTH    = 32;
   localparam int ALU_OP_WIDTH = 4;

   // Shared ALU operation codes
   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd0;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'd1;

   // RV32M funct3 encodings
   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   // rs1 is treated as signed by every signed op, including MULHSU
   function automatic logic src1_signed(input logic [2:0] op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   // rs2 is signed for the fully-signed ops only
   function automatic logic src2_signed(input logic [2:0] op);
      return (op == MD_MUL) || (op == MD_MULH) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq.sv
// +----------------------------------------------------------------------------+
// | Module      : muldiv_seq                                                   |
// | Description : Iterative RV32M multiply/divide unit borrowing an external   |
// |               shared ALU. Shift-add multiply and restoring divide, 32      |
// |               iterations, followed by a one-cycle sign-fix stage.          |
// | Ports       : clk, rst_n            - clock, async active-low reset        |
// |               req_*                 - valid/ready request (op, rs1, rs2)   |
// |               resp_*                - valid/ready registered response      |
// |               flush                 - abort any operation in flight        |
// |               busy                  - unit not idle                        |
// |               alu_req/op/src1/src2  - shared ALU request; alu_res returns  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [2:0]              req_op,
   input  logic [WIDTH-1:0]        req_src1,
   input  logic [WIDTH-1:0]        req_src2,
   output logic                    resp_valid,
   output logic [WIDTH-1:0]        resp_data,
   input  logic                    resp_ready,
   input  logic                    flush,
   output logic                    busy,
   output logic                    alu_req,
   output logic [ALU_OP_WIDTH-1:0] alu_op,
   output logic [WIDTH-1:0]        alu_src1,
   output logic [WIDTH-1:0]        alu_src2,
   input  logic [WIDTH-1:0]        alu_res
);

   localparam int CNT_W = $clog2(WIDTH);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   // hi: product high / partial remainder; lo: multiplier / dividend->quotient
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   // opnd: multiplicand for MUL*, divisor for DIV*/REM*
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;

   // Request decode
   logic             accept;
   logic             s1_neg, s2_neg;
   logic [WIDTH-1:0] mag1, mag2;
   logic             div_zero, div_ovf;

   assign accept   = req_valid & req_ready & ~flush;
   assign s1_neg   = src1_signed(req_op) & req_src1[WIDTH-1];
   assign s2_neg   = src2_signed(req_op) & req_src2[WIDTH-1];
   assign mag1     = s1_neg ? -req_src1 : req_src1;
   assign mag2     = s2_neg ? -req_src2 : req_src2;
   assign div_zero = req_op[2] & (req_src2 == '0);
   // Only signed DIV/REM can overflow: most-negative / -1
   assign div_ovf  = req_op[2] & ~req_op[0] &
                     (req_src1 == {1'b1, {(WIDTH-1){1'b0}}}) & (req_src2 == '1);

   // Iteration datapath
   logic [WIDTH:0]     div_s;
   logic               div_ge;
   logic               mul_carry;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign div_s     = {hi_q, lo_q[WIDTH-1]};
   // Bit WIDTH set means the shifted remainder already exceeds any divisor
   assign div_ge    = div_s[WIDTH] | (div_s[WIDTH-1:0] >= opnd_q);
   // Unsigned wrap of hi + addend reveals the carry out of the shared ALU
   assign mul_carry = (alu_res < hi_q);
   assign prod_fix  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
   assign quo_fix   = neg_q ? -lo_q : lo_q;
   assign rem_fix   = neg_q ? -hi_q : hi_q;

   // Outputs
   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign resp_valid = (state_q == ST_DONE);
   assign alu_req    = (state_q == ST_CALC);
   assign resp_data  = resp_data_q;

   always_comb begin : alu_share_mux
      alu_op   = ALU_ADD;
      alu_src1 = '0;
      alu_src2 = '0;
      if (alu_req) begin
         if (op_q[2]) begin
            alu_op   = ALU_SUB;
            alu_src1 = div_s[WIDTH-1:0];
            alu_src2 = opnd_q;
         end else begin
            alu_op   = ALU_ADD;
            alu_src1 = hi_q;
            alu_src2 = lo_q[0] ? opnd_q : '0;
         end
      end
   end

   always_comb begin : next_state
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      opnd_d      = opnd_q;
      neg_d       = neg_q;
      resp_data_d = resp_data_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d  = req_op;
               // REM takes the dividend sign; all others the sign product
               neg_d = (req_op == MD_REM) ? s1_neg : (s1_neg ^ s2_neg);
               if (div_zero) begin
                  resp_data_d = req_op[1] ? req_src1 : '1;
                  state_d     = ST_DONE;
               end else if (div_ovf) begin
                  resp_data_d = req_op[1] ? '0 : req_src1;
                  state_d     = ST_DONE;
               end else begin
                  hi_d    = '0;
                  cnt_d   = CNT_W'(WIDTH-1);
                  state_d = ST_CALC;
                  if (req_op[2]) begin
                     lo_d   = mag1;
                     opnd_d = mag2;
                  end else begin
                     lo_d   = mag2;
                     opnd_d = mag1;
                  end
               end
            end
         end

         ST_CALC: begin
            if (op_q[2]) begin
               hi_d = div_ge ? alu_res : div_s[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], div_ge};
            end else begin
               hi_d = {mul_carry, alu_res[WIDTH-1:1]};
               lo_d = {alu_res[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end
         end

         ST_FIX: begin
            case (op_q)
               MD_MUL:                       resp_data_d = prod_fix[WIDTH-1:0];
               MD_MULH, MD_MULHSU, MD_MULHU: resp_data_d = prod_fix[2*WIDTH-1:WIDTH];
               MD_DIV, MD_DIVU:              resp_data_d = quo_fix;
               default:                      resp_data_d = rem_fix;
            endcase
            state_d = ST_DONE;
         end

         ST_DONE: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         opnd_q      <= '0;
         neg_q       <= 1'b0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         opnd_q      <= opnd_d;
         neg_q       <= neg_d;
         resp_data_q <= resp_data_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_muldiv_seq                                                |
// | Description : Self-checking bench for muldiv_seq: vector table, random     |
// |               vectors against a reference model, scoreboard queue, and     |
// |               hand-written backpressure / flush / reset sequences.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    req_valid = 1'b0;
   logic                    req_ready;
   logic [2:0]              req_op = 3'b000;
   logic [31:0]             req_src1 = '0;
   logic [31:0]             req_src2 = '0;
   logic                    resp_valid;
   logic [31:0]             resp_data;
   logic                    resp_ready = 1'b1;
   logic                    flush = 1'b0;
   logic                    busy;
   logic                    alu_req;
   logic [ALU_OP_WIDTH-1:0] alu_op;
   logic [31:0]             alu_src1;
   logic [31:0]             alu_src2;
   logic [31:0]             alu_res;

   // Shared ALU stand-in
   assign alu_res = (alu_op == ALU_SUB) ? (alu_src1 - alu_src2) : (alu_src1 + alu_src2);

   muldiv_seq #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_src1   (req_src1),
      .req_src2   (req_src2),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .flush      (flush),
      .busy       (busy),
      .alu_req    (alu_req),
      .alu_op     (alu_op),
      .alu_src1   (alu_src1),
      .alu_src2   (alu_src2),
      .alu_res    (alu_res)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        special;
   } sb_t;

   vec_t tbl[18];
   sb_t  sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 1'b0;
      if (b == 32'h0) return 1'b1;
      return ((op == MD_DIV) || (op == MD_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0]        up;
      logic [31:0]        r;
      case (op)
         MD_MUL:    r = a * b;
         MD_MULH: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r  = sp[63:32];
         end
         MD_MULHSU: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});
            r  = sp[63:32];
         end
         MD_MULHU: begin
            up = {32'h0, a} * {32'h0, b};
            r  = up[63:32];
         end
         MD_DIV: begin
            if (b == 32'h0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = $signed(a) / $signed(b);
         end
         MD_DIVU:   r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         MD_REM: begin
            if (b == 32'h0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = $signed(a) % $signed(b);
         end
         default:   r = (b == 32'h0) ? a : a % b;
      endcase
      return r;
   endfunction

   // One request through the whole pipeline with latency and ALU-ownership checks
   task automatic run_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
      sb_t e;
      int  lat;
      int  alu_cnt;
      e.data    = exp;
      e.special = is_special(op, a, b);
      sb_q.push_back(e);
      @(negedge clk);
      check({name, "/req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_src1  = a;
      req_src2  = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat       = 0;
      alu_cnt   = 0;
      while (!resp_valid && lat < 60) begin
         if (alu_req) alu_cnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      e = sb_q.pop_front();
      if (!resp_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL %s/timeout: got no resp_valid expected response within 60 cycles", name);
      end else begin
         check({name, "/data"}, resp_data, e.data);
         check({name, "/latency"}, 32'(lat), e.special ? 32'd0 : 32'd33);
         check({name, "/alu_cycles"}, 32'(alu_cnt), e.special ? 32'd0 : 32'd32);
      end
      @(posedge clk);
      #1;
      check({name, "/idle_after_hs"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sb_t e;
      int  lat;
      logic seen;

      tbl[0]  = '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      tbl[1]  = '{MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      tbl[2]  = '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      tbl[3]  = '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
      tbl[4]  = '{MD_DIVU,   32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF};
      tbl[5]  = '{MD_REMU,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007};
      tbl[6]  = '{MD_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
      tbl[7]  = '{MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
      tbl[8]  = '{MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
      tbl[9]  = '{MD_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
      tbl[10] = '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tbl[11] = '{MD_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E};
      tbl[12] = '{MD_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002};
      tbl[13] = '{MD_MUL,    32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1};
      tbl[14] = '{MD_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
      tbl[15] = '{MD_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
      tbl[16] = '{MD_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
      tbl[17] = '{MD_DIV,    32'h8000_0000, 32'h0000_0002, 32'hC000_0000};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst/busy",       32'(busy),       32'd0);
      check("rst/resp_valid", 32'(resp_valid), 32'd0);
      check("rst/resp_data",  resp_data,       32'd0);
      check("rst/alu_req",    32'(alu_req),    32'd0);
      check("rst/alu_op",     32'(alu_op),     32'(ALU_ADD));
      check("rst/alu_src",    alu_src1 | alu_src2, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst/req_ready",  32'(req_ready),  32'd1);

      // Vector table
      foreach (tbl[i]) begin
         run_vec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));
      end

      // Random vectors against the reference model
      for (int i = 0; i < 16; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         run_vec(op, a, b, ref_model(op, a, b), $sformatf("rand%0d", i));
      end

      // Backpressure: response must hold while resp_ready is low
      resp_ready = 1'b0;
      e.data     = 32'hFFFF_FFFE;
      e.special  = 1'b0;
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = MD_MULHU;
      req_src1  = 32'hFFFF_FFFF;
      req_src2  = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      e = sb_q.pop_front();
      check("bp/latency", 32'(lat), 32'd33);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp/data%0d", i),  resp_data,         e.data);
         check($sformatf("bp/valid%0d", i), 32'(resp_valid),   32'd1);
         check($sformatf("bp/ready%0d", i), 32'(req_ready),    32'd0);
      end
      check("bp/alu_idle", alu_src1 | alu_src2, 32'd0);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp/hs_busy",  32'(busy),       32'd0);
      check("bp/hs_valid", 32'(resp_valid), 32'd0);
      check("bp/hs_ready", 32'(req_ready),  32'd1);

      // Flush mid-CALC: back to IDLE on the next edge, no response
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = MD_DIVU;
      req_src1  = 32'd1000;
      req_src2  = 32'd3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("flush/pre_alu_req", 32'(alu_req), 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush/busy",       32'(busy),       32'd0);
      check("flush/alu_req",    32'(alu_req),    32'd0);
      check("flush/resp_valid", 32'(resp_valid), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      check("flush/no_resp", 32'(seen), 32'd0);

      // Reset pulse mid-CALC: asynchronous return to IDLE
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = MD_MUL;
      req_src1  = 32'h1234_5678;
      req_src2  = 32'h0000_0009;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("arst/pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst/busy",      32'(busy),       32'd0);
      check("arst/alu_req",   32'(alu_req),    32'd0);
      check("arst/resp_data", resp_data,       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      check("arst/no_resp", 32'(seen), 32'd0);
      run_vec(MD_DIVU, 32'd100, 32'd7, 32'h0000_000E, "post_rst_divu");

      check("sb/empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
